// File: rtl/cnt_arbiter.sv
// cnt_arbiter: shares one up/down counter datapath between NREQ requesters.
// Requesters are arbitrated, the granted command (load, up, down or hold) is
// sequenced onto the counter control lines, and a done pulse is returned.
// Build option: define CNT_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no round-robin pointer); default build is round-robin.

module cnt_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int LENW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    cmd_op,
    input  logic [DW*NREQ-1:0]   cmd_data,
    input  logic [LENW*NREQ-1:0] cmd_len,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 ld_cnt,
    output logic                 updn_cnt,
    output logic                 count_enb,
    output logic [DW-1:0]        cnt_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   gnt_idx;
    logic [1:0]      cap_op;
    logic [DW-1:0]   cap_data;
    logic [LENW-1:0] remaining;

    logic [IW-1:0]   scan_start;
    logic [IW-1:0]   scan_pos;
    logic            scan_found;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic [1:0]      pick_op;
    logic [DW-1:0]   pick_data;
    logic [LENW-1:0] pick_len;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (int'(idx) >= NREQ - 1) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

`ifdef CNT_ARB_FIXED_PRIO_EN
    assign scan_start = '0;
`else
    logic [IW-1:0] rr_ptr;

    assign scan_start = rr_ptr;

    // Round-robin pointer: moves past the served requester on completion or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == DONE || (state == RUN && !req[gnt_idx])) begin
            rr_ptr <= next_idx(gnt_idx);
        end
    end
`endif

    // Arbiter: first asserted request scanning upward from the start index, wrapping, plus its command slices.
    always_comb begin
        pick_idx   = '0;
        scan_found = 1'b0;
        scan_pos   = scan_start;
        for (int k = 0; k < NREQ; k++) begin
            if (!scan_found && req[scan_pos]) begin
                pick_idx   = scan_pos;
                scan_found = 1'b1;
            end
            scan_pos = next_idx(scan_pos);
        end
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
        pick_op           = cmd_op[2*pick_idx +: 2];
        pick_data         = cmd_data[DW*pick_idx +: DW];
        pick_len          = cmd_len[LENW*pick_idx +: LENW];
    end

    // Sequencer: grants and captures in IDLE, drives counter controls in RUN, pulses done in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            ld_cnt    <= 1'b1;
            updn_cnt  <= 1'b0;
            count_enb <= 1'b0;
            cnt_data  <= '0;
            gnt_idx   <= '0;
            cap_op    <= OP_HOLD;
            cap_data  <= '0;
            remaining <= '0;
        end else begin
            done      <= '0;
            ld_cnt    <= 1'b1;
            updn_cnt  <= 1'b0;
            count_enb <= 1'b0;
            cnt_data  <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= pick_oh;
                        gnt_idx  <= pick_idx;
                        cap_op   <= pick_op;
                        cap_data <= pick_data;
                        busy     <= 1'b1;
                        if (pick_op == OP_LOAD) begin
                            remaining <= LEN_ONE;
                            state     <= RUN;
                        end else if (pick_len == '0) begin
                            remaining <= '0;
                            done      <= pick_oh;
                            state     <= DONE;
                        end else begin
                            remaining <= pick_len;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!req[gnt_idx]) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (remaining != '0) begin
                        remaining <= remaining - LEN_ONE;
                        case (cap_op)
                            OP_LOAD: begin
                                ld_cnt   <= 1'b0;
                                cnt_data <= cap_data;
                            end
                            OP_UP: begin
                                count_enb <= 1'b1;
                                updn_cnt  <= 1'b1;
                            end
                            OP_DOWN: begin
                                count_enb <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        done  <= gnt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_arbiter.sv
// tb_cnt_arbiter: directed self-checking bench for cnt_arbiter with
// hand-computed cycle positions. Expected arbitration order follows the
// CNT_ARB_FIXED_PRIO_EN build option.

module tb_cnt_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int LENW = 8;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req;
   logic [2*NREQ-1:0]    cmdOp;
   logic [DW*NREQ-1:0]   cmdData;
   logic [LENW*NREQ-1:0] cmdLen;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic                 busy;
   logic                 ldCnt;
   logic                 updnCnt;
   logic                 countEnb;
   logic [DW-1:0]        cntData;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      int enbCnt;
      int ldCnt;
      int doneCnt;
      int doneAt;
      int lastEnbAt;
      int badData;
      int badDir;
      int badGnt;
      int invViol;
      int timedOut;
   } result_t;

   cnt_arbiter #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .cmd_op    (cmdOp),
      .cmd_data  (cmdData),
      .cmd_len   (cmdLen),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .ld_cnt    (ldCnt),
      .updn_cnt  (updnCnt),
      .count_enb (countEnb),
      .cnt_data  (cntData)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Writes one requester's command slices
   task automatic setCmd(input int idx, input logic [1:0] op, input logic [15:0] data, input logic [7:0] len);
      cmdOp[2*idx +: 2]     = op;
      cmdData[DW*idx +: DW] = data;
      cmdLen[LENW*idx +: 8] = len;
   endtask

   // Issues one command on a single requester and observes it to completion or abort.
   // dropAt > 0 drops req during the cycle in which the dropAt-th count_enb cycle is seen.
   // The command inputs are scrambled after grant to show the captured copy is used.
   task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [15:0] data,
                                input logic [7:0] len, input int dropAt, output result_t r);
      logic [NREQ-1:0] ohIdx;
      bit finished;
      r = '{default: 0};
      ohIdx = 4'b0001 << idx;
      setCmd(idx, op, data, len);
      req[idx] = 1'b1;
      finished = 1'b0;
      for (int c = 1; c <= 60 && !finished; c++) begin
         @(negedge clk);
         if (c == 1) setCmd(idx, op ^ 2'b11, ~data, 8'hFF);
         if (countEnb) begin
            r.enbCnt++;
            r.lastEnbAt = c;
            if (updnCnt !== (op == OP_UP)) r.badDir++;
         end
         if (!ldCnt) begin
            r.ldCnt++;
            if (cntData !== data) r.badData++;
         end
         if (!ldCnt && countEnb) r.invViol++;
         if (busy && gnt !== ohIdx) r.badGnt++;
         if (done !== '0) begin
            r.doneCnt++;
            r.doneAt = c;
            if (done !== ohIdx) r.badGnt++;
            req[idx] = 1'b0;
         end
         if (dropAt > 0 && r.enbCnt == dropAt && req[idx]) req[idx] = 1'b0;
         if (!req[idx] && !busy) finished = 1'b1;
      end
      if (!finished) r.timedOut = 1;
      if (gnt !== '0) r.badGnt++;
   endtask

   int order[5];
   int expOrder[5];
   int doneSeen;
   int badRr;
   int firstGnt, gnt0At, ldAt, done0At, done3At, holdActivity;
   int expFirstGnt, expGnt0At, expLdAt, expDone0At, expDone3At;
   bit finished;
   result_t res;

   initial begin
`ifdef CNT_ARB_FIXED_PRIO_EN
      expOrder    = '{0, 0, 0, 0, 0};
      expFirstGnt = 1;
      expGnt0At   = 1;
      expLdAt     = 2;
      expDone0At  = 3;
      expDone3At  = 10;
`else
      expOrder    = '{0, 1, 2, 3, 0};
      expFirstGnt = 8;
      expGnt0At   = 8;
      expLdAt     = 9;
      expDone0At  = 10;
      expDone3At  = 6;
`endif
      rst     = 1'b1;
      req     = '0;
      cmdOp   = '0;
      cmdData = '0;
      cmdLen  = '0;
      repeat (2) @(negedge clk);

      checkOutput("rst gnt", 32'(gnt), 32'h0);
      checkOutput("rst done", 32'(done), 32'h0);
      checkOutput("rst busy", 32'(busy), 32'h0);
      checkOutput("rst ld_cnt", 32'(ldCnt), 32'h1);
      checkOutput("rst updn_cnt", 32'(updnCnt), 32'h0);
      checkOutput("rst count_enb", 32'(countEnb), 32'h0);
      checkOutput("rst cnt_data", 32'(cntData), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(0, OP_LOAD, 16'h1234, 8'd7, 0, res);
      checkOutput("load ld cycles", 32'(res.ldCnt), 32'd1);
      checkOutput("load data", 32'(res.badData), 32'd0);
      checkOutput("load enb cycles", 32'(res.enbCnt), 32'd0);
      checkOutput("load done count", 32'(res.doneCnt), 32'd1);
      checkOutput("load done cycle", 32'(res.doneAt), 32'd3);
      checkOutput("load gnt", 32'(res.badGnt), 32'd0);
      checkOutput("load timeout", 32'(res.timedOut), 32'd0);

      applyStimulus(1, OP_UP, 16'h0000, 8'd3, 0, res);
      checkOutput("up enb cycles", 32'(res.enbCnt), 32'd3);
      checkOutput("up last enb", 32'(res.lastEnbAt), 32'd4);
      checkOutput("up direction", 32'(res.badDir), 32'd0);
      checkOutput("up done cycle", 32'(res.doneAt), 32'd5);
      checkOutput("up done count", 32'(res.doneCnt), 32'd1);
      checkOutput("up ld cycles", 32'(res.ldCnt), 32'd0);
      checkOutput("up gnt", 32'(res.badGnt), 32'd0);
      checkOutput("up invariant", 32'(res.invViol), 32'd0);
      checkOutput("up timeout", 32'(res.timedOut), 32'd0);

      applyStimulus(1, OP_DOWN, 16'h0000, 8'd0, 0, res);
      checkOutput("len0 enb cycles", 32'(res.enbCnt), 32'd0);
      checkOutput("len0 done cycle", 32'(res.doneAt), 32'd1);
      checkOutput("len0 done count", 32'(res.doneCnt), 32'd1);
      checkOutput("len0 gnt", 32'(res.badGnt), 32'd0);
      checkOutput("len0 timeout", 32'(res.timedOut), 32'd0);

      setCmd(2, OP_UP, 16'h0000, 8'd5);
      req[2] = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("pre-reset enb", 32'(countEnb), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrun rst gnt", 32'(gnt), 32'h0);
      checkOutput("midrun rst done", 32'(done), 32'h0);
      checkOutput("midrun rst busy", 32'(busy), 32'h0);
      checkOutput("midrun rst ld_cnt", 32'(ldCnt), 32'h1);
      checkOutput("midrun rst updn_cnt", 32'(updnCnt), 32'h0);
      checkOutput("midrun rst count_enb", 32'(countEnb), 32'h0);
      checkOutput("midrun rst cnt_data", 32'(cntData), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      doneSeen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done !== '0 || busy) doneSeen++;
      end
      checkOutput("midrun no done", 32'(doneSeen), 32'd0);

      for (int i = 0; i < NREQ; i++) setCmd(i, OP_LOAD, 16'h1000 + 16'(i), 8'd0);
      req = 4'hF;
      doneSeen = 0;
      badRr = 0;
      finished = 1'b0;
      for (int c = 1; c <= 60 && !finished; c++) begin
         @(negedge clk);
         if (!ldCnt) begin
            for (int i = 0; i < NREQ; i++)
               if (gnt[i] && cntData !== 16'h1000 + 16'(i)) badRr++;
         end
         if ((gnt & (gnt - 4'd1)) !== '0) badRr++;
         if (done !== '0) begin
            if (done !== gnt) badRr++;
            for (int i = 0; i < NREQ; i++)
               if (done[i] && doneSeen < 5) order[doneSeen] = i;
            doneSeen++;
            if (doneSeen == 5) req = '0;
         end
         if (doneSeen >= 5 && !busy) finished = 1'b1;
      end
      checkOutput("rr timeout", 32'(finished), 32'd1);
      checkOutput("rr done count", 32'(doneSeen), 32'd5);
      checkOutput("rr done/gnt", 32'(badRr), 32'd0);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("rr order %0d", i), 32'(order[i]), 32'(expOrder[i]));

      applyStimulus(2, OP_DOWN, 16'h0000, 8'd10, 5, res);
      checkOutput("abort enb cycles", 32'(res.enbCnt), 32'd5);
      checkOutput("abort no done", 32'(res.doneCnt), 32'd0);
      checkOutput("abort direction", 32'(res.badDir), 32'd0);
      checkOutput("abort gnt", 32'(res.badGnt), 32'd0);
      checkOutput("abort timeout", 32'(res.timedOut), 32'd0);

      setCmd(3, OP_HOLD, 16'h5555, 8'd4);
      setCmd(0, OP_LOAD, 16'hBEEF, 8'd0);
      req = 4'b1001;
      firstGnt = 0; gnt0At = 0; ldAt = 0; done0At = 0; done3At = 0; holdActivity = 0;
      finished = 1'b0;
      for (int c = 1; c <= 40 && !finished; c++) begin
         @(negedge clk);
         if (c == 1) firstGnt = int'(gnt);
         if (gnt == 4'b1000 && (countEnb || !ldCnt)) holdActivity++;
         if (gnt == 4'b0001 && gnt0At == 0) gnt0At = c;
         if (!ldCnt && ldAt == 0) ldAt = c;
         if (done[3]) begin
            done3At = c;
            req[3] = 1'b0;
         end
         if (done[0]) begin
            done0At = c;
            req[0] = 1'b0;
         end
         if (req == '0 && !busy) finished = 1'b1;
      end
      checkOutput("hold timeout", 32'(finished), 32'd1);
      checkOutput("hold first gnt", 32'(firstGnt), 32'(expFirstGnt));
      checkOutput("hold activity", 32'(holdActivity), 32'd0);
      checkOutput("hold done3 cycle", 32'(done3At), 32'(expDone3At));
      checkOutput("hold gnt0 cycle", 32'(gnt0At), 32'(expGnt0At));
      checkOutput("hold load cycle", 32'(ldAt), 32'(expLdAt));
      checkOutput("hold done0 cycle", 32'(done0At), 32'(expDone0At));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/cnt_arbiter.md
Name: cnt_arbiter

Overview:
- Shares one 16-bit up/down counter datapath between NREQ requesters.
- Each requester presents a command: load, count up, count down, or hold, with a data word and a step count.
- The block arbitrates round-robin, then sequences the counter control lines (ld_cnt, updn_cnt, count_enb, data) for the granted command, and pulses done on completion.
- Sits directly in front of the counter; the counter's data_out is not consumed here.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 16, counter data width
- LENW, 8, width of the per-command step count

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request; held high until done or abort
- cmd_op  input  2*NREQ  per-requester op, slice i = [2i+1:2i]: 00 load, 01 up, 10 down, 11 hold
- cmd_data  input  DW*NREQ  per-requester load value, slice i
- cmd_len  input  LENW*NREQ  per-requester step count, slice i
- gnt  output  NREQ  one-hot grant
- done  output  NREQ  one-cycle completion pulse to the granted requester
- busy  output  1  high whenever state != IDLE
- ld_cnt  output  1  counter load strobe, active-low
- updn_cnt  output  1  1 = up, 0 = down
- count_enb  output  1  counter step enable
- cnt_data  output  DW  value driven to the counter's data input

Behaviour:
- All outputs are registered.
- Reset values (asserted at any edge with rst=1, including mid-RUN):
  - gnt=0, done=0, busy=0
  - ld_cnt=1, updn_cnt=0, count_enb=0, cnt_data=0
  - rr pointer=0, state=IDLE
  - No done is issued for a command killed by reset.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If req != 0, select the first asserted req scanning upward from the rr pointer, wrapping.
  - At that edge: set gnt[i]; capture op, data and len of requester i; go to RUN.
  - If req = 0, stay in IDLE; all control outputs stay inactive.
- RUN, driving outputs from the captured command:
  - load: ld_cnt=0 and cnt_data=data for exactly 1 cycle; len is ignored; then DONE.
  - up/down: count_enb=1, updn_cnt=1 (up) or 0 (down), for exactly len consecutive cycles; then DONE.
  - hold: count_enb=0, ld_cnt=1 for len cycles (reserves the counter); then DONE.
  - len=0 with up/down/hold: no RUN cycles; go IDLE→DONE directly, with count_enb never asserted.
- DONE:
  - done[i]=1 for one cycle; gnt[i] stays 1 during this cycle, then clears.
  - rr pointer becomes i+1 mod NREQ; state returns to IDLE.
  - Control outputs are inactive.
- Timing:
  - req sampled high at edge k: gnt visible after edge k; first counter-control cycle is k+1..k+2.
  - Back-to-back commands have 1 IDLE cycle between DONE and the next RUN.
- Abort: req[i] low while in RUN.
  - Detected at the next edge: control outputs go inactive, gnt clears, no done, pointer advances, state goes to IDLE.
  - The cycle in which req drops still performs its operation.
- Held inputs: cmd_* of the granted requester may change after grant; the captured copy is used.
- Other req lines are ignored until IDLE.
- Reassertion: a requester may reassert req in the cycle after its done. It then has lowest priority under round-robin.
- Step counter is LENW bits, counting down from len to 1 with no wrap; max run length is 2^LENW-1.
- Invariants:
  - ld_cnt=0 and count_enb=1 are never asserted together.
  - At most one gnt bit is set.

Optional Feature:
- CNT_ARB_FIXED_PRIO_EN
- Defined: fixed priority; lowest index wins in IDLE, and the rr pointer is not implemented.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- rst=1 for 2 cycles mid-RUN of an up/len=5 command → next edge: all outputs at reset values, busy=0, no done pulse.
- req[0] load data=16'h1234 → exactly 1 cycle with ld_cnt=0 and cnt_data=16'h1234, then done[0] pulse; count_enb stays 0 throughout.
- req[1] up len=3 → count_enb=1, updn_cnt=1 for exactly 3 cycles, done[1] the cycle after; down len=0 → done with count_enb never high.
- All req high, continuously reissued → grants 0,1,2,3,0 in order, one done per grant; with CNT_ARB_FIXED_PRIO_EN defined, requester 0 wins every arbitration.
- req[2] down len=10, req[2] dropped after 4 RUN cycles → count_enb high for 5 cycles, gnt clears, done[2] never pulses, next arbitration starts at index 3.
- req[3] hold len=4 while req[0] also pending → no counter activity for 4 cycles; req[0] granted after done[3] + 1 IDLE cycle.
